// File: rtl/can_lin_mb_pkg.sv
// Shared definitions for the CAN/LIN mailbox register file.
package can_lin_mb_pkg;

   localparam int unsigned REGS_PER_CH = 4;

   typedef enum logic [1:0] {
      REG_TXD  = 2'd0,
      REG_RXD  = 2'd1,
      REG_STAT = 2'd2,
      REG_IEN  = 2'd3
   } reg_e;

   localparam int unsigned ST_TXREQ   = 0;
   localparam int unsigned ST_TXDONE  = 1;
   localparam int unsigned ST_MSGREC  = 2;
   localparam int unsigned ST_OVERRUN = 3;

endpackage

// File: rtl/mb_channel.sv
// One mailbox channel: TX/RX data, sticky status flags, IRQ enables.
module mb_channel
   import can_lin_mb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  reg_e                  reg_sel,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  tx_done,
   input  logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] rx_data,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  txreq,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  irq_term
);

   logic [DATA_WIDTH-1:0] txd;
   logic [DATA_WIDTH-1:0] rxd;
   logic                  txdone;
   logic                  msgrec;
   logic                  overrun;
   logic [3:1]            ien;

   logic wr_txd, wr_stat, wr_ien;
   logic set_txreq, clr_txdone, clr_msgrec, clr_overrun;
   logic done_evt;

   assign wr_txd      = wr_en && (reg_sel == REG_TXD);
   assign wr_stat     = wr_en && (reg_sel == REG_STAT);
   assign wr_ien      = wr_en && (reg_sel == REG_IEN);
   assign set_txreq   = wr_stat && wdata[ST_TXREQ];
   assign clr_txdone  = wr_stat && wdata[ST_TXDONE];
   assign clr_msgrec  = wr_stat && wdata[ST_MSGREC];
   assign clr_overrun = wr_stat && wdata[ST_OVERRUN];
   // a host W1S of TXREQ in the same cycle masks tx_done entirely
   assign done_evt    = tx_done && txreq && !set_txreq;

   // register state; hardware set terms are OR-ed after the W1C mask so they win
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         txd     <= '0;
         rxd     <= '0;
         txreq   <= 1'b0;
         txdone  <= 1'b0;
         msgrec  <= 1'b0;
         overrun <= 1'b0;
         ien     <= '0;
      end else begin
         if (wr_txd && !txreq)
            txd <= wdata;
         if (set_txreq)
            txreq <= 1'b1;
         else if (done_evt)
            txreq <= 1'b0;
         txdone <= done_evt | (txdone & ~clr_txdone);
         if (rx_valid && !msgrec)
            rxd <= rx_data;
         // any rx event keeps MSGREC high, even against a same-cycle W1C
         msgrec  <= rx_valid | (msgrec & ~clr_msgrec);
         overrun <= (rx_valid & msgrec) | (overrun & ~clr_overrun);
         if (wr_ien)
            ien <= wdata[3:1];
      end
   end

   // register read view for the selected offset
   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_TXD:  rd_data = txd;
         REG_RXD:  rd_data = rxd;
         REG_STAT: rd_data[3:0] = {overrun, msgrec, txdone, txreq};
         REG_IEN:  rd_data[3:1] = ien;
         default:  rd_data = '0;
      endcase
   end

   assign tx_data  = txd;
   assign irq_term = |({overrun, msgrec, txdone} & ien);

endmodule

// File: rtl/can_lin_mailbox_rf.sv
// Mailbox register file top: address decode, registered read port, irq OR.
module can_lin_mailbox_rf
   import can_lin_mb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         host_wr,
   input  logic                         host_rd,
   input  logic [ADDR_WIDTH-1:0]        host_addr,
   input  logic [DATA_WIDTH-1:0]        host_wdata,
   output logic [DATA_WIDTH-1:0]        host_rdata,
   output logic                         host_rvalid,
   output logic [NUM_CH*DATA_WIDTH-1:0] tx_data,
   output logic [NUM_CH-1:0]            txreq,
   input  logic [NUM_CH-1:0]            tx_done,
   input  logic [NUM_CH-1:0]            rx_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] rx_data,
   output logic                         irq
);

   int unsigned           ch_idx;
   reg_e                  reg_sel;
   logic [DATA_WIDTH-1:0] ch_rd [NUM_CH];
   logic [NUM_CH-1:0]     irq_terms;
   logic [DATA_WIDTH-1:0] rd_mux;

   assign ch_idx  = 32'(host_addr) / REGS_PER_CH;
   assign reg_sel = reg_e'(host_addr[1:0]);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic wr_en;
      assign wr_en = host_wr && (ch_idx == c);
      mb_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (wr_en),
         .reg_sel  (reg_sel),
         .wdata    (host_wdata),
         .tx_done  (tx_done[c]),
         .rx_valid (rx_valid[c]),
         .rx_data  (rx_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .tx_data  (tx_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .txreq    (txreq[c]),
         .rd_data  (ch_rd[c]),
         .irq_term (irq_terms[c])
      );
   end

   // select the addressed channel; out-of-range channels read as zero
   always_comb begin
      rd_mux = '0;
      for (int unsigned c = 0; c < NUM_CH; c++)
         if (ch_idx == c)
            rd_mux = ch_rd[c];
   end

   // registered read return and combined interrupt
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
         irq         <= 1'b0;
      end else begin
         host_rvalid <= host_rd && !host_wr;
         if (host_rd && !host_wr)
            host_rdata <= rd_mux;
         irq <= |irq_terms;
      end
   end

endmodule
